// File: rtl/sim_monitor_pkg.sv
// sim_monitor_pkg: shared types for the end-of-test monitor.
//   ch_state_e : per-channel FSM encoding (also exported on ch_state for debug)
//   ST_*       : encodings of the 2-bit status output
//   chw()      : width of a channel index, never below 1 bit
package sim_monitor_pkg;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SETTLE = 3'd1,
    PASS   = 3'd2,
    FAIL   = 3'd3,
    HANG   = 3'd4
  } ch_state_e;

  localparam logic [1:0] ST_RUN  = 2'b00;
  localparam logic [1:0] ST_PASS = 2'b01;
  localparam logic [1:0] ST_FAIL = 2'b10;
  localparam logic [1:0] ST_HANG = 2'b11;

  function automatic int chw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sim_monitor_if.sv
// sim_monitor_if: signature inputs and verdict outputs of the monitor.
//   Inputs : ch_done, ch_pass, ch_commit (one bit per channel), ch_testnum
//   Outputs: finish, status, fail_ch, fail_testnum, cycle_cnt, instret, ch_state
// Per-channel vectors are packed [NUM_CH-1:0][W-1:0], so channel i sits at
// bits [i*W +: W] of the flattened vector.
// Modports: slave = monitor side, master = bench/driver side.
interface sim_monitor_if #(
  parameter int NUM_CH = 1,
  parameter int XLEN   = 64,
  parameter int CNT_W  = 32
);
  localparam int CHW = sim_monitor_pkg::chw(NUM_CH);

  logic [NUM_CH-1:0]            ch_done;
  logic [NUM_CH-1:0]            ch_pass;
  logic [NUM_CH-1:0]            ch_commit;
  logic [NUM_CH-1:0][XLEN-1:0]  ch_testnum;

  logic                         finish;
  logic [1:0]                   status;
  logic [CHW-1:0]               fail_ch;
  logic [XLEN-1:0]              fail_testnum;
  logic [CNT_W-1:0]             cycle_cnt;
  logic [NUM_CH-1:0][CNT_W-1:0] instret;
  logic [NUM_CH-1:0][2:0]       ch_state;

  modport slave (
    input  ch_done, ch_pass, ch_commit, ch_testnum,
    output finish, status, fail_ch, fail_testnum, cycle_cnt, instret, ch_state
  );

  modport master (
    output ch_done, ch_pass, ch_commit, ch_testnum,
    input  finish, status, fail_ch, fail_testnum, cycle_cnt, instret, ch_state
  );

endinterface

// File: rtl/sim_monitor_ch.sv
// sim_monitor_ch: one monitored hart.
//   clk, rst      : clock, async active-low reset
//   freeze_i      : global finish; holds every register
//   done_i/pass_i : signature flags, testnum_i : x3 value
//   commit_i      : retire pulse
//   state_o       : ch_state_e encoding
//   instret_o     : saturating retire count
//   testnum_o     : testnum captured on the verdict / hang edge
module sim_monitor_ch
  import sim_monitor_pkg::*;
#(
  parameter int XLEN          = 64,
  parameter int CNT_W         = 32,
  parameter int SETTLE_CYCLES = 2,
  parameter int HANG_CYCLES   = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze_i,
  input  logic             done_i,
  input  logic             pass_i,
  input  logic             commit_i,
  input  logic [XLEN-1:0]  testnum_i,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instret_o,
  output logic [XLEN-1:0]  testnum_o
);

  localparam int              SW         = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0]   SETTLE_LIM = SW'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] HANG_LIM  = CNT_W'(HANG_CYCLES);

  ch_state_e        state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [XLEN-1:0]  tn_q, tn_d;

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    idle_d    = idle_q;
    instret_d = instret_q;
    tn_d      = tn_q;
    if (!freeze_i) begin
      if (commit_i && instret_q != '1) instret_d = instret_q + CNT_W'(1);
      // idle keeps counting through SETTLE so a rejected glitch does not
      // hide a hang; only the check itself is limited to RUN
      if (state_q == RUN || state_q == SETTLE)
        idle_d = commit_i ? '0 : ((idle_q == '1) ? idle_q : idle_q + CNT_W'(1));
      case (state_q)
        RUN: begin
          if (done_i) begin
            if (SETTLE_CYCLES <= 1) begin
              state_d = pass_i ? PASS : FAIL;
              tn_d    = testnum_i;
            end else begin
              state_d  = SETTLE;
              settle_d = SW'(1);
            end
          end else if (HANG_CYCLES != 0 && idle_d >= HANG_LIM) begin
            state_d = HANG;
            tn_d    = testnum_i;
          end
        end
        SETTLE: begin
          if (!done_i) begin
            state_d = RUN;
          end else begin
            settle_d = settle_q + SW'(1);
            if (settle_d >= SETTLE_LIM) begin
              state_d = pass_i ? PASS : FAIL;
              tn_d    = testnum_i;
            end
          end
        end
        default: ;  // terminal states hold until reset
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      settle_q  <= '0;
      idle_q    <= '0;
      instret_q <= '0;
      tn_q      <= '0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      idle_q    <= idle_d;
      instret_q <= instret_d;
      tn_q      <= tn_d;
    end
  end

  assign state_o   = state_q;
  assign instret_o = instret_q;
  assign testnum_o = tn_q;

endmodule

// File: rtl/sim_monitor.sv
// sim_monitor: end-of-test monitor for NUM_CH harts.
//   clk, rst : bench clock, async active-low reset
//   mon      : sim_monitor_if.slave (signature inputs, sticky verdict outputs)
// Holds the global cycle counter, the verdict priority encoder and the
// sticky finish register; per-hart logic lives in sim_monitor_ch.
module sim_monitor
  import sim_monitor_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int NUM_CH         = 1,
  parameter int CNT_W          = 32,
  parameter int SETTLE_CYCLES  = 2,
  parameter int HANG_CYCLES    = 4096,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int STOP_ON_FAIL   = 1
) (
  input logic         clk,
  input logic         rst,
  sim_monitor_if.slave mon
);

  localparam int               CHW    = chw(NUM_CH);
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [NUM_CH-1:0][2:0]       st;
  logic [NUM_CH-1:0][CNT_W-1:0] ins;
  logic [NUM_CH-1:0][XLEN-1:0]  tn;

  logic             finish_q, finish_d;
  logic [1:0]       status_q, status_d;
  logic [CHW-1:0]   fail_ch_q, fail_ch_d;
  logic [XLEN-1:0]  fail_tn_q, fail_tn_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;

  logic             any_fail, any_hang, all_term, to_hit, trig;
  logic [CHW-1:0]   f_idx, h_idx;
  logic [XLEN-1:0]  f_tn, h_tn;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sim_monitor_ch #(
      .XLEN(XLEN), .CNT_W(CNT_W),
      .SETTLE_CYCLES(SETTLE_CYCLES), .HANG_CYCLES(HANG_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .freeze_i (finish_q),
      .done_i   (mon.ch_done[g]),
      .pass_i   (mon.ch_pass[g]),
      .commit_i (mon.ch_commit[g]),
      .testnum_i(mon.ch_testnum[g]),
      .state_o  (st[g]),
      .instret_o(ins[g]),
      .testnum_o(tn[g])
    );
  end

  always_comb begin
    any_fail = 1'b0;
    any_hang = 1'b0;
    all_term = 1'b1;
    f_idx    = '0;
    h_idx    = '0;
    f_tn     = '0;
    h_tn     = '0;
    // scan downwards so the lowest index is the last one written
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (st[i] == FAIL) begin any_fail = 1'b1; f_idx = CHW'(i); f_tn = tn[i]; end
      if (st[i] == HANG) begin any_hang = 1'b1; h_idx = CHW'(i); h_tn = tn[i]; end
      if (st[i] == RUN || st[i] == SETTLE) all_term = 1'b0;
    end
    to_hit = (TIMEOUT_CYCLES != 0) && (cycle_q == TO_LIM);
    trig   = all_term || ((STOP_ON_FAIL != 0) && (any_fail || any_hang)) || to_hit;

    finish_d  = finish_q;
    status_d  = status_q;
    fail_ch_d = fail_ch_q;
    fail_tn_d = fail_tn_q;
    cycle_d   = cycle_q;
    if (!finish_q) begin
      // the timeout edge must not advance the counter past TIMEOUT_CYCLES-1
      if (!to_hit && cycle_q != '1) cycle_d = cycle_q + CNT_W'(1);
      if (trig) begin
        finish_d = 1'b1;
        if (any_fail) begin
          status_d  = ST_FAIL;
          fail_ch_d = f_idx;
          fail_tn_d = f_tn;
        end else if (any_hang) begin
          status_d  = ST_HANG;
          fail_ch_d = h_idx;
          fail_tn_d = h_tn;
        end else if (to_hit) begin
          status_d  = ST_HANG;
        end else begin
          status_d  = ST_PASS;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      finish_q  <= 1'b0;
      status_q  <= ST_RUN;
      fail_ch_q <= '0;
      fail_tn_q <= '0;
      cycle_q   <= '0;
    end else begin
      finish_q  <= finish_d;
      status_q  <= status_d;
      fail_ch_q <= fail_ch_d;
      fail_tn_q <= fail_tn_d;
      cycle_q   <= cycle_d;
    end
  end

  assign mon.finish       = finish_q;
  assign mon.status       = status_q;
  assign mon.fail_ch      = fail_ch_q;
  assign mon.fail_testnum = fail_tn_q;
  assign mon.cycle_cnt    = cycle_q;
  assign mon.instret      = ins;
  assign mon.ch_state     = st;

endmodule

// File: tb/tb_sim_monitor.sv
// tb_sim_monitor: randomized trials against a streak/idle-count reference
// model of the monitor, every output compared every cycle.
module tb_sim_monitor;

  localparam int NC  = 4;
  localparam int XL  = 32;
  localparam int CW  = 16;
  localparam int SET = 2;
  localparam int HNG = 16;
  localparam int TMO = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sim_monitor_if #(.NUM_CH(NC), .XLEN(XL), .CNT_W(CW)) mon ();

  sim_monitor #(
    .XLEN(XL), .NUM_CH(NC), .CNT_W(CW), .SETTLE_CYCLES(SET),
    .HANG_CYCLES(HNG), .TIMEOUT_CYCLES(TMO), .STOP_ON_FAIL(1)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .mon(mon)
  );

  int n_chk, n_fail;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---- reference model -------------------------------------------------
  // per channel: run length of consecutive done-high edges, edges since the
  // last commit, retire count, verdict (0 none, 2 pass, 3 fail, 4 hang)
  int             m_streak [NC];
  int             m_idle   [NC];
  int             m_ins    [NC];
  int             m_v      [NC];
  logic [XL-1:0]  m_tn     [NC];
  int             m_cyc;
  bit             m_fin;
  int             m_st, m_fch;
  logic [XL-1:0]  m_ftn;

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_streak[i] = 0; m_idle[i] = 0; m_ins[i] = 0; m_v[i] = 0; m_tn[i] = '0;
    end
    m_cyc = 0; m_fin = 0; m_st = 0; m_fch = 0; m_ftn = '0;
  endtask

  task automatic model_edge(input logic [NC-1:0] d, input logic [NC-1:0] p,
                            input logic [NC-1:0] c, input logic [NC-1:0][XL-1:0] tn);
    int fi, hi;
    bit allt, to;
    if (m_fin) return;
    // verdict uses the channel results already visible before this edge
    fi = -1; hi = -1; allt = 1;
    for (int i = 0; i < NC; i++) begin
      if (m_v[i] == 3 && fi < 0) fi = i;
      if (m_v[i] == 4 && hi < 0) hi = i;
      if (m_v[i] == 0) allt = 0;
    end
    to = (m_cyc == TMO - 1);
    if (allt || fi >= 0 || hi >= 0 || to) begin
      m_fin = 1;
      if (fi >= 0)      begin m_st = 2; m_fch = fi; m_ftn = m_tn[fi]; end
      else if (hi >= 0) begin m_st = 3; m_fch = hi; m_ftn = m_tn[hi]; end
      else if (to)        m_st = 3;
      else                m_st = 1;
    end
    if (!to) m_cyc++;
    for (int i = 0; i < NC; i++) begin
      if (c[i]) m_ins[i]++;
      if (m_v[i] == 0) begin
        m_idle[i] = c[i] ? 0 : m_idle[i] + 1;
        if (d[i]) begin
          m_streak[i]++;
          if (m_streak[i] >= SET) begin m_v[i] = p[i] ? 2 : 3; m_tn[i] = tn[i]; end
        end else begin
          if (m_streak[i] == 0 && m_idle[i] >= HNG) begin m_v[i] = 4; m_tn[i] = tn[i]; end
          m_streak[i] = 0;
        end
      end
    end
  endtask

  task automatic compare();
    logic [NC-1:0][CW-1:0] ei;
    logic [NC-1:0][2:0]    es;
    for (int i = 0; i < NC; i++) begin
      ei[i] = CW'(m_ins[i]);
      es[i] = (m_v[i] != 0) ? 3'(m_v[i]) : ((m_streak[i] > 0) ? 3'd1 : 3'd0);
    end
    chk("finish",    128'(mon.finish),       128'(m_fin));
    chk("status",    128'(mon.status),       128'(m_st));
    chk("fail_ch",   128'(mon.fail_ch),      128'(m_fch));
    chk("fail_tn",   128'(mon.fail_testnum), 128'(m_ftn));
    chk("cycle_cnt", 128'(mon.cycle_cnt),    128'(m_cyc));
    chk("instret",   128'(mon.instret),      128'(ei));
    chk("ch_state",  128'(mon.ch_state),     128'(es));
  endtask

  // ---- stimulus plan ---------------------------------------------------
  int            ds  [NC];   // first cycle of steady done
  int            gl  [NC];   // single-cycle done glitch
  int            pm  [NC];   // pass: 0 random, 1 always, 2 never
  int            cp  [NC];   // commit probability (%)
  int            stp [NC];   // cycle after which commits stop
  logic [XL-1:0] tv  [NC];
  int            len;

  task automatic plan(input int tr);
    int mode, r;
    mode = (tr == 0) ? 4 : (tr == 1) ? 3 : (tr == 39) ? 5 : int'($urandom_range(0, 2));
    len  = 130;
    for (int i = 0; i < NC; i++) begin
      ds[i] = 1000; gl[i] = -1; pm[i] = 0; cp[i] = 70; stp[i] = 1000; tv[i] = $urandom;
    end
    case (mode)
      0: begin  // mixed pass/fail with glitches, sometimes aborted by reset
        for (int i = 0; i < NC; i++) begin
          ds[i] = int'($urandom_range(3, 70));
          gl[i] = int'($urandom_range(0, 80));
          pm[i] = int'($urandom_range(0, 2));
        end
        if ($urandom_range(0, 1) == 1) len = int'($urandom_range(5, 60));
      end
      1: begin  // one channel stops retiring
        r = int'($urandom_range(0, NC - 1));
        for (int i = 0; i < NC; i++) begin ds[i] = int'($urandom_range(30, 90)); pm[i] = 1; end
        ds[r]  = 1000;
        stp[r] = int'($urandom_range(0, 30));
      end
      2: ;      // commits flowing, done never: global timeout
      3: begin  // channels 2 and 3 fail on the same edge
        ds[2] = 10; ds[3] = 10; pm[2] = 2; pm[3] = 2;
        ds[0] = 20; ds[1] = 25; pm[0] = 1; pm[1] = 1;
      end
      4: begin  // stop while every channel is in SETTLE
        for (int i = 0; i < NC; i++) begin ds[i] = 5; pm[i] = 1; cp[i] = 100; end
        len = 6;
      end
      default: begin  // clean pass
        for (int i = 0; i < NC; i++) begin ds[i] = int'($urandom_range(3, 40)); pm[i] = 1; end
      end
    endcase
  endtask

  task automatic cyc(input int t);
    logic [NC-1:0]         d, p, c;
    logic [NC-1:0][XL-1:0] tn;
    for (int i = 0; i < NC; i++) begin
      d[i]  = (t >= ds[i]) || (t == gl[i]);
      p[i]  = (pm[i] == 1) ? 1'b1 : (pm[i] == 2) ? 1'b0 : ($urandom_range(0, 9) < 7);
      c[i]  = (t < stp[i]) && ($urandom_range(0, 99) < cp[i]);
      tn[i] = tv[i] ^ XL'(t);
    end
    mon.ch_done = d; mon.ch_pass = p; mon.ch_commit = c; mon.ch_testnum = tn;
    @(posedge clk);
    model_edge(d, p, c, tn);
    @(negedge clk);
    compare();
  endtask

  // called at a falling edge; asserts reset between clock edges and checks
  // that outputs clear before any edge arrives
  task automatic do_reset();
    mon.ch_done = '0; mon.ch_pass = '0; mon.ch_commit = '0; mon.ch_testnum = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_finish",  128'(mon.finish),       128'(0));
    chk("rst_status",  128'(mon.status),       128'(0));
    chk("rst_fail_ch", 128'(mon.fail_ch),      128'(0));
    chk("rst_fail_tn", 128'(mon.fail_testnum), 128'(0));
    chk("rst_cycle",   128'(mon.cycle_cnt),    128'(0));
    chk("rst_instret", 128'(mon.instret),      128'(0));
    chk("rst_state",   128'(mon.ch_state),     128'(0));
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    model_reset();
    @(negedge clk);
    for (int tr = 0; tr < 40; tr++) begin
      plan(tr);
      do_reset();
      for (int t = 0; t < len; t++) cyc(t);
    end
    do_reset();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/sim_monitor.md
Name: sim_monitor

Overview:
- Simulation-side end-of-test monitor; instantiated in the bench top next to soc.
- Watches up to NUM_CH harts' test-signature registers: done (x26), pass (x27) and test number (x3), plus a per-hart retire pulse.
- Debounces done, decides pass/fail per channel, detects hangs and a global timeout.
- Drives one sticky finish/status result that the bench polls to print its verdict and call $finish.

Parameters:
- XLEN, 64, width of the testnum signature per channel.
- NUM_CH, 1, number of monitored harts (1..8).
- CNT_W, 32, width of the cycle and instret counters.
- SETTLE_CYCLES, 2, consecutive sampled-high cycles of done required before a verdict (>=1).
- HANG_CYCLES, 4096, cycles without a retire before a channel is declared hung; 0 disables.
- TIMEOUT_CYCLES, 1000000, global cycle limit; 0 disables.
- STOP_ON_FAIL, 1, 1 = finish on first FAIL/HANG; 0 = wait for all channels to reach a terminal state.

Ports:
- clk  in  1  bench clock
- rst  in  1  asynchronous, active-low reset
- ch_done  in  NUM_CH  per-channel done flag (x26 != 0)
- ch_pass  in  NUM_CH  per-channel pass flag (x27 == 1)
- ch_testnum  in  NUM_CH*XLEN  per-channel x3, channel i at bits [i*XLEN +: XLEN]
- ch_commit  in  NUM_CH  one-cycle retire pulse per channel
- finish  out  1  sticky; test over
- status  out  2  00 running, 01 pass, 10 fail, 11 hang/timeout
- fail_ch  out  CHW  lowest failing channel index; CHW = max(1,$clog2(NUM_CH))
- fail_testnum  out  XLEN  latched testnum of fail_ch
- cycle_cnt  out  CNT_W  cycles since reset release
- instret  out  NUM_CH*CNT_W  per-channel retire count
- ch_state  out  NUM_CH*3  per-channel FSM state, for debug

Behaviour:
- Reset:
  - rst low asynchronously clears every register.
  - finish=0, status=00, fail_ch=0, fail_testnum=0, cycle_cnt=0, instret=0, all ch_state=RUN.
  - Reset asserted mid-test clears everything, including a latched verdict.
- Per-channel FSM (states RUN, SETTLE, PASS, FAIL, HANG), evaluated on every rising edge:
  - RUN:
    - ch_done=1 -> SETTLE with settle count 1.
    - If SETTLE_CYCLES=1, ch_done=1 goes straight to the verdict instead.
    - Idle counter clears on ch_commit and increments otherwise.
    - Idle counter reaches HANG_CYCLES with ch_done=0 -> HANG.
  - SETTLE:
    - ch_done=0 -> RUN (glitch rejected; idle counter is not reset).
    - Otherwise the settle count increments.
    - When the count reaches SETTLE_CYCLES, go to PASS if ch_pass=1 else FAIL. ch_pass and ch_testnum are sampled on that same edge.
    - Hang detection is suspended while in SETTLE.
  - PASS, FAIL, HANG are terminal and held until reset.
  - ch_commit and ch_done high in the same cycle: the commit is counted and the done handling proceeds normally.
- Counters:
  - cycle_cnt increments every cycle while finish=0.
  - instret[i] increments on ch_commit[i] while finish=0.
  - Both saturate at all-ones and never wrap.
- Global finish (registered; asserts on the edge after the triggering channel state is visible):
  - Triggers when all channels are terminal.
  - Or when STOP_ON_FAIL=1 and any channel is FAIL/HANG.
  - Or when TIMEOUT_CYCLES!=0 and cycle_cnt reaches TIMEOUT_CYCLES-1.
- status on finish, with priority FAIL(10) > HANG or timeout(11) > PASS(01):
  - Timeout with no FAIL -> 11, even if some channels have passed.
- fail_ch / fail_testnum:
  - Set to the lowest-index FAIL channel, else the lowest-index HANG channel.
  - Same-cycle multi-channel failures resolve to the lowest index.
  - Untouched (0) on pass or timeout.
- Once finish=1:
  - All outputs freeze, and channel FSMs stop transitioning.
  - Later input changes have no effect.

Decomposition:
- Package sim_monitor_pkg:
  - ch_state enum: RUN=0, SETTLE=1, PASS=2, FAIL=3, HANG=4.
  - status codes ST_RUN, ST_PASS, ST_FAIL, ST_HANG.
  - clog2-based CHW helper.
- One sub-module sim_monitor_ch:
  - Per-channel FSM, settle and idle counters, instret counter, testnum latch.
  - Generated NUM_CH times.
- The top holds cycle_cnt, the priority encoder for the verdict, and the finish register.

Test Plan:
1. NUM_CH=1, SETTLE=2: pulse commit 10 times, then hold done=1, pass=1 -> PASS two edges later; finish=1 one edge after that; status=01, instret=10.
2. NUM_CH=1: done=1 for one cycle then 0, later done=1, pass=0, testnum=0x17 held -> glitch ignored (back to RUN); then FAIL, status=10, fail_ch=0, fail_testnum=0x17.
3. NUM_CH=4, STOP_ON_FAIL=1: channels 2 and 3 settle to fail on the same edge -> fail_ch=2, status=10; the other channels' later done is ignored; counters frozen.
4. HANG_CYCLES=16: no commits and done=0 -> HANG after 16 cycles; status=11, fail_ch=0; a commit on cycle 15 restarts the count.
5. TIMEOUT_CYCLES=100, commits flowing, done never set -> finish when cycle_cnt=99; status=11, cycle_cnt held at 99.
6. Assert rst low asynchronously while in SETTLE, and again after finish -> all outputs return to reset values immediately; a normal pass sequence afterwards finishes correctly.
